// File: rtl/servo_pulse_decoder_if.sv
// servo_pulse_decoder_if: PWM input and decoded-width outputs of the servo pulse decoder
//   pwm_in      raw asynchronous servo/RC PWM pulse train (driven by master)
//   width_out   last accepted high time in ticks (12 bits)
//   width_valid one-cycle strobe, width_out was updated
//   range_err   one-cycle strobe, a completed pulse was rejected
//   signal_lost level, high while no valid pulse train is present
interface servo_pulse_decoder_if;
    logic        pwm_in;
    logic [11:0] width_out;
    logic        width_valid;
    logic        range_err;
    logic        signal_lost;
    modport master (output pwm_in, input width_out, width_valid, range_err, signal_lost);
    modport slave  (input pwm_in, output width_out, width_valid, range_err, signal_lost);
endinterface

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures servo PWM high time in prescaler ticks with range and loss detection
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    servo_pulse_decoder_if.slave (pwm_in in; width_out, width_valid, range_err, signal_lost out)
//   Optional macro SERVO_DECODE_FILTER_EN inserts a 3-sample majority glitch filter after the synchronizer.
module servo_pulse_decoder #(
    parameter int CLK_DIV   = 50,
    parameter int WIDTH_MIN = 900,
    parameter int WIDTH_MAX = 2100,
    parameter int TIMEOUT   = 25000
) (
    input logic                  clk,
    input logic                  reset,
    servo_pulse_decoder_if.slave bus
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SERVO_DECODE_FILTER_EN
    localparam int WARM = 5;
`else
    localparam int WARM = 2;
`endif
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);
    localparam logic [11:0]   WMIN     = 12'(WIDTH_MIN);
    localparam logic [11:0]   WMAX     = 12'(WIDTH_MAX);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    state_t          state;
    logic [1:0]      sync;
    logic [WARM-1:0] warm;
    logic            x, x_d, rise, fall;
    logic [PW-1:0]   pre;
    logic [11:0]     cnt, cnt_inc;
    logic [TW-1:0]   to_cnt;
    logic            tick, to_hit, ready, in_range;

`ifdef SERVO_DECODE_FILTER_EN
    logic [2:0] hist;
    always_ff @(posedge clk)
        hist <= reset ? 3'b000 : {hist[1:0], sync[1]};
    assign x = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign x = sync[1];
`endif

    // warm fills with ones as reset zeros drain out of the input pipeline;
    // until then x may show a false low that would let a pulse already
    // high at reset release be measured.
    assign ready    = warm[WARM-1];
    assign tick     = pre == PRE_LAST;
    assign to_hit   = to_cnt == TO_LAST;
    // the fall cycle still counts, so a high time of N*CLK_DIV clocks gives exactly N ticks
    assign cnt_inc  = (tick && cnt != 12'hfff) ? cnt + 12'd1 : cnt;
    assign in_range = cnt_inc >= WMIN && cnt_inc <= WMAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SYNC;
            sync            <= '0;
            warm            <= '0;
            x_d             <= 1'b0;
            rise            <= 1'b0;
            fall            <= 1'b0;
            pre             <= '0;
            cnt             <= '0;
            to_cnt          <= '0;
            bus.width_out   <= '0;
            bus.width_valid <= 1'b0;
            bus.range_err   <= 1'b0;
            bus.signal_lost <= 1'b1;
        end else begin
            sync            <= {sync[0], bus.pwm_in};
            warm            <= {warm[WARM-2:0], 1'b1};
            x_d             <= x;
            rise            <= x & ~x_d;
            fall            <= ~x & x_d;
            pre             <= tick ? '0 : pre + 1'b1;
            bus.width_valid <= 1'b0;
            bus.range_err   <= 1'b0;
            if (state != SYNC && tick && !to_hit)
                to_cnt <= to_cnt + 1'b1;
            case (state)
                SYNC: begin
                    to_cnt <= '0;
                    if (ready && !x)
                        state <= LOW;
                end
                LOW: begin
                    if (to_hit) begin
                        bus.signal_lost <= 1'b1;
                        state           <= SYNC;
                    end else if (rise) begin
                        cnt    <= '0;
                        to_cnt <= '0;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    // timeout has priority over a simultaneous fall
                    if (to_hit) begin
                        bus.signal_lost <= 1'b1;
                        state           <= SYNC;
                    end else if (fall) begin
                        state <= LOW;
                        if (in_range) begin
                            bus.width_out   <= cnt_inc;
                            bus.width_valid <= 1'b1;
                            bus.signal_lost <= 1'b0;
                        end else begin
                            bus.range_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder: randomized and directed pulse trains checked against a width-rule model
module tb_servo_pulse_decoder;
    localparam int DIV  = 2;
    localparam int WMIN = 90;
    localparam int WMAX = 210;
    localparam int TO   = 5000;
`ifdef SERVO_DECODE_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    servo_pulse_decoder_if bus();

    servo_pulse_decoder #(
        .CLK_DIV  (DIV),
        .WIDTH_MIN(WMIN),
        .WIDTH_MAX(WMAX),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int nv = 0;
    int ne = 0;
    int both = 0;
    logic [11:0] exp_w = '0;
    logic exp_lost = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.width_valid) nv++;
            if (bus.range_err) ne++;
            if (bus.width_valid && bus.range_err) both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        check($sformatf("%s.width_out", tag), 32'(bus.width_out), 0);
        check($sformatf("%s.width_valid", tag), 32'(bus.width_valid), 0);
        check($sformatf("%s.range_err", tag), 32'(bus.range_err), 0);
        check($sformatf("%s.signal_lost", tag), 32'(bus.signal_lost), 1);
    endtask

    task automatic pulse(input int h, input int l);
        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat (h * DIV) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        repeat (l * DIV) @(posedge clk);
    endtask

    // Model: a pulse of h ticks reads as min(h,4095); accepted iff within [WMIN,WMAX]
    task automatic run(input string tag, input int h, input int l);
        int v0;
        int e0;
        int m;
        bit ok;
        v0 = nv;
        e0 = ne;
        m  = h > 4095 ? 4095 : h;
        ok = m >= WMIN && m <= WMAX;
        pulse(h, l);
        @(negedge clk);
        if (ok) begin
            exp_w    = 12'(m);
            exp_lost = 1'b0;
        end
        check($sformatf("%s.valid_cnt", tag), 32'(nv - v0), 32'(ok));
        check($sformatf("%s.err_cnt", tag), 32'(ne - e0), 32'(!ok));
        check($sformatf("%s.width_out", tag), 32'(bus.width_out), 32'(exp_w));
        check($sformatf("%s.signal_lost", tag), 32'(bus.signal_lost), 32'(exp_lost));
    endtask

    initial begin
        int v0;
        int e0;
        bus.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("idle.signal_lost", 32'(bus.signal_lost), 1);

        run("first", 150, 100);

        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat (150 * DIV) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check("lat.early", 32'(bus.width_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("lat.strobe", 32'(bus.width_valid), 1);
        check("lat.width_out", 32'(bus.width_out), 150);
        repeat (50 * DIV) @(posedge clk);

        run("below_min", WMIN - 1, 40);
        run("at_min", WMIN, 40);
        run("at_max", WMAX, 40);
        run("above_max", WMAX + 1, 40);
        run("short80", 80, 40);
        run("long220", 220, 40);

        for (int i = 0; i < 16; i++)
            run($sformatf("rand%0d", i), int'($urandom_range(60, 240)), int'($urandom_range(20, 80)));

        run("saturate", 4200, 50);

        v0 = nv;
        e0 = ne;
        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat ((TO - 1) * DIV) @(posedge clk);
        @(negedge clk);
        check("timeout.before", 32'(bus.signal_lost), 0);
        repeat (2 * DIV + 8) @(posedge clk);
        @(negedge clk);
        check("timeout.after", 32'(bus.signal_lost), 1);
        repeat (150 * DIV) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        repeat (50 * DIV) @(posedge clk);
        @(negedge clk);
        exp_lost = 1'b1;
        check("timeout.valid_cnt", 32'(nv - v0), 0);
        check("timeout.err_cnt", 32'(ne - e0), 0);
        check("timeout.width_out", 32'(bus.width_out), 32'(exp_w));

        run("recover", 150, 50);

        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat (60 * DIV) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("midreset");
        exp_w    = '0;
        exp_lost = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        v0 = nv;
        e0 = ne;
        repeat (100 * DIV) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        repeat (50 * DIV) @(posedge clk);
        @(negedge clk);
        check("midreset.valid_cnt", 32'(nv - v0), 0);
        check("midreset.err_cnt", 32'(ne - e0), 0);
        run("after_reset", 100, 50);

        v0 = nv;
        e0 = ne;
        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat (75 * DIV) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        @(posedge clk);
        #1 bus.pwm_in = 1'b1;
        repeat (75 * DIV - 1) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        repeat (50 * DIV) @(posedge clk);
        @(negedge clk);
`ifdef SERVO_DECODE_FILTER_EN
        exp_w = 12'd150;
        check("glitch.valid_cnt", 32'(nv - v0), 1);
        check("glitch.err_cnt", 32'(ne - e0), 0);
`else
        check("glitch.valid_cnt", 32'(nv - v0), 0);
        check("glitch.err_cnt", 32'(ne - e0), 2);
`endif
        check("glitch.width_out", 32'(bus.width_out), 32'(exp_w));

        check("exclusive", 32'(both), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
